sumador_serie: RTL

Parametrised digit-serial adder/subtractor, the multi-cycle successor of the single-bit `sumador` cell. It accepts two WIDTH-bit operands on a start strobe and processes DIGIT bits per clock through a DIGIT-bit ripple cell. It then presents the result with carry and flags and a one-cycle done pulse. It sits between the operand registers and the display/result path of the lab datapath, and trades latency for area.

---
 rtl/sumador_pkg.sv | 19 +
 rtl/sumador_digito.sv | 30 +++
 rtl/sumador_serie.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sumador_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor (sumador_serie).
// Holds the FSM state encoding, operation codes and cycle-count helper.
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_SUMA  = 1'b0;
    localparam logic OP_RESTA = 1'b1;

    // Number of digit cycles needed to sweep a WIDTH-bit operand.
    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/sumador_digito.sv
// Combinational DIGIT-bit ripple adder cell used once per clock by sumador_serie.
// Also exposes the carry into the most significant bit so the top can derive overflow.
module sumador_digito #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic v_c;

    always_comb begin
        s     = '0;
        c_msb = 1'b0;
        v_c   = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = v_c;
            end
            s[i] = a[i] ^ b[i] ^ v_c;
            v_c  = (a[i] & b[i]) | (v_c & (a[i] ^ b[i]));
        end
        co = v_c;
    end

endmodule

// File: rtl/sumador_serie.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, result registered with a done pulse.
// Define SUMADOR_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied low.
module sumador_serie
    import sumador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             select,
    output logic [WIDTH-1:0] O,
    output logic             Co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = calc_n(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("sumador_serie: DIGIT must be at least 1");
        end
        if ((WIDTH % DIGIT) != 0) begin : g_bad_width
            $error("sumador_serie: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_o;
    logic             r_co;

    logic             w_load;
    logic             w_last;
    logic             w_calc;
    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0] w_res_next;

    sumador_digito #(.DIGIT(DIGIT)) u_digito (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .ci    (r_carry),
        .s     (w_s),
        .co    (w_co),
        .c_msb (w_c_msb)
    );

    // New sum digit enters from the MSB side so the first digit ends up at bit 0.
    assign w_cat      = {w_s, r_res};
    assign w_res_next = w_cat[WIDTH+DIGIT-1:DIGIT];

    assign w_calc = (r_state == CALC);
    assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last = w_calc && (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CALC;
            CALC:    if (r_cnt == CW'(N - 1)) w_state_next = DONE;
            DONE:    w_state_next = start ? CALC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_a     <= A;
                r_b     <= (select == OP_RESTA) ? ~B : B;
                r_carry <= (select == OP_RESTA) ? ~Ci : Ci;
                r_cnt   <= '0;
            end else if (w_calc) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_carry <= w_co;
                r_res   <= w_res_next;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // Visible result only changes on the final digit, never showing partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o  <= '0;
            r_co <= 1'b0;
        end else if (w_last) begin
            r_o  <= w_res_next;
            r_co <= w_co;
        end
    end

`ifdef SUMADOR_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_c_msb ^ w_co;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused;
    assign w_unused = w_c_msb;
    assign ovf      = 1'b0;
`endif

    assign O    = r_o;
    assign Co   = r_co;
    assign busy = (r_state == CALC);
    assign done = (r_state == DONE);

endmodule
